// File: rtl/register_file_sb.sv
// Scoreboarded register file: combinational reads with optional write-back forwarding,
// plus per-register busy tracking, a registered busy population count and a sticky issue-conflict flag.
module register_file_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            stage_clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic [AW:0]     busy_count,
  output logic            wr_conflict
);

  logic [XLEN-1:0] x_q [NREG];
  logic [XLEN-1:0] x_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_count_q, busy_count_d;
  logic            wr_conflict_q, wr_conflict_d;
  logic            wb_we, issue_we;
  logic            fwd1, fwd2;

  assign wb_we    = wb_en && (wb_rd != '0);
  assign issue_we = issue_en && (issue_rd != '0);
  assign fwd1     = (BYPASS != 0) && wb_we && (wb_rd == rs1);
  assign fwd2     = (BYPASS != 0) && wb_we && (wb_rd == rs2);

  // A forwarded write-back also hides the busy bit, unless an issue re-arms it this same edge.
  always_comb begin
    rs1_data = x_q[rs1];
    rs1_busy = busy_q[rs1];
    if (rs1 == '0) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
    end else if (fwd1) begin
      rs1_data = wb_data;
      if (!(issue_we && (issue_rd == rs1))) rs1_busy = 1'b0;
    end

    rs2_data = x_q[rs2];
    rs2_busy = busy_q[rs2];
    if (rs2 == '0) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
    end else if (fwd2) begin
      rs2_data = wb_data;
      if (!(issue_we && (issue_rd == rs2))) rs2_busy = 1'b0;
    end
  end

  assign stall       = rs1_busy | rs2_busy;
  assign busy_count  = busy_count_q;
  assign wr_conflict = wr_conflict_q;

  // Write-back clears busy first so that a same-edge issue to the same register wins.
  always_comb begin
    for (int i = 0; i < NREG; i++) x_d[i] = x_q[i];
    busy_d = busy_q;
    if (wb_we) begin
      x_d[wb_rd]    = wb_data;
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_we) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    wr_conflict_d = wr_conflict_q |
                    (issue_we && busy_q[issue_rd] && !(wb_we && (wb_rd == issue_rd)));

    busy_count_d = '0;
    for (int i = 0; i < NREG; i++) busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
  end

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) x_q[i] <= '0;
      busy_q        <= '0;
      busy_count_q  <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) x_q[i] <= x_d[i];
      busy_q        <= busy_d;
      busy_count_q  <= busy_count_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one forwarding instance and one non-forwarding
// instance driven by the same stimulus, checked against hand-computed values.
module tb_register_file_sb;

  logic        stage_clk;
  logic        reset;
  logic [4:0]  rs1, rs2, wb_rd, issue_rd;
  logic        wb_en, issue_en;
  logic [31:0] wb_data;

  logic [31:0] b1_rs1_data, b1_rs2_data, b0_rs1_data, b0_rs2_data;
  logic        b1_rs1_busy, b1_rs2_busy, b1_stall, b1_wr_conflict;
  logic        b0_rs1_busy, b0_rs2_busy, b0_stall, b0_wr_conflict;
  logic [5:0]  b1_busy_count, b0_busy_count;

  int test_count = 0;
  int fail_count = 0;

  register_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_b1 (
    .stage_clk(stage_clk), .reset(reset),
    .rs1(rs1), .rs2(rs2),
    .rs1_data(b1_rs1_data), .rs2_data(b1_rs2_data),
    .rs1_busy(b1_rs1_busy), .rs2_busy(b1_rs2_busy), .stall(b1_stall),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .busy_count(b1_busy_count), .wr_conflict(b1_wr_conflict)
  );

  register_file_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_b0 (
    .stage_clk(stage_clk), .reset(reset),
    .rs1(rs1), .rs2(rs2),
    .rs1_data(b0_rs1_data), .rs2_data(b0_rs2_data),
    .rs1_busy(b0_rs1_busy), .rs2_busy(b0_rs2_busy), .stall(b0_stall),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .busy_count(b0_busy_count), .wr_conflict(b0_wr_conflict)
  );

  initial stage_clk = 1'b0;
  always #5 stage_clk = ~stage_clk;

  task automatic applyStimulus(input logic w_en, input logic [4:0] w_rd, input logic [31:0] w_data,
                               input logic i_en, input logic [4:0] i_rd,
                               input logic [4:0] r1, input logic [4:0] r2);
    wb_en    = w_en;
    wb_rd    = w_rd;
    wb_data  = w_data;
    issue_en = i_en;
    issue_rd = i_rd;
    rs1      = r1;
    rs2      = r2;
    #1;
  endtask

  task automatic tick;
    @(posedge stage_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // requests during reset: forwarding still visible, nothing stored
    applyStimulus(1, 5, 32'h111, 1, 4, 5, 4);
    checkOutput("rst_fwd_b1",      b1_rs1_data, 32'h111);
    checkOutput("rst_fwd_b0",      b0_rs1_data, 32'h0);
    checkOutput("rst_stall_b1",    32'(b1_stall), 32'h0);
    checkOutput("rst_stall_b0",    32'(b0_stall), 32'h0);
    checkOutput("rst_count",       32'(b1_busy_count), 32'h0);
    checkOutput("rst_conflict",    32'(b1_wr_conflict), 32'h0);
    tick;
    checkOutput("rst_edge_count",  32'(b1_busy_count), 32'h0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 5, 4);
    checkOutput("rst_discard_wb",  b1_rs1_data, 32'h0);
    checkOutput("rst_discard_iss", 32'(b1_rs2_busy), 32'h0);

    // basic write-back to x5
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    checkOutput("wb5_fwd_b1",      b1_rs1_data, 32'hDEADBEEF);
    checkOutput("wb5_nofwd_b0",    b0_rs1_data, 32'h0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 5, 0);
    checkOutput("wb5_read_b1",     b1_rs1_data, 32'hDEADBEEF);
    checkOutput("wb5_read_b0",     b0_rs1_data, 32'hDEADBEEF);
    checkOutput("wb5_busy",        32'(b1_rs1_busy), 32'h0);

    // writes to x0 are ignored
    applyStimulus(1, 0, 32'h12345678, 0, 0, 0, 0);
    checkOutput("x0_fwd",          b1_rs2_data, 32'h0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_read",         b1_rs2_data, 32'h0);
    checkOutput("x0_stall",        32'(b1_stall), 32'h0);
    checkOutput("x0_count",        32'(b1_busy_count), 32'h0);

    // issue x7, write back three cycles later
    applyStimulus(0, 0, 0, 1, 7, 7, 0);
    checkOutput("iss7_pre_stall",  32'(b1_stall), 32'h0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 7, 0);
    checkOutput("iss7_stall_b1",   32'(b1_stall), 32'h1);
    checkOutput("iss7_stall_b0",   32'(b0_stall), 32'h1);
    checkOutput("iss7_count_b1",   32'(b1_busy_count), 32'h1);
    checkOutput("iss7_count_b0",   32'(b0_busy_count), 32'h1);
    tick;
    tick;
    checkOutput("iss7_hold_b0",    32'(b0_stall), 32'h1);
    applyStimulus(1, 7, 32'hA5, 0, 0, 7, 0);
    checkOutput("wb7_fwd_data_b1", b1_rs1_data, 32'hA5);
    checkOutput("wb7_fwd_stall_b1",32'(b1_stall), 32'h0);
    checkOutput("wb7_old_data_b0", b0_rs1_data, 32'h0);
    checkOutput("wb7_stall_b0",    32'(b0_stall), 32'h1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 7, 0);
    checkOutput("wb7_done_stall_b0", 32'(b0_stall), 32'h0);
    checkOutput("wb7_done_data_b0",  b0_rs1_data, 32'hA5);
    checkOutput("wb7_done_count",    32'(b1_busy_count), 32'h0);

    // issue and write-back to x3 on the same edge: data written, busy stays
    applyStimulus(1, 3, 32'h55, 1, 3, 3, 0);
    checkOutput("same3_pre_busy",  32'(b1_rs1_busy), 32'h0);
    checkOutput("same3_fwd",       b1_rs1_data, 32'h55);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    checkOutput("same3_data",      b1_rs1_data, 32'h55);
    checkOutput("same3_busy",      32'(b1_rs1_busy), 32'h1);
    checkOutput("same3_count",     32'(b1_busy_count), 32'h1);
    checkOutput("same3_conflict",  32'(b1_wr_conflict), 32'h0);

    // write-back to busy x3 while issuing x10
    applyStimulus(1, 3, 32'h66, 1, 10, 3, 10);
    checkOutput("wb3_busy_b1",     32'(b1_rs1_busy), 32'h0);
    checkOutput("wb3_busy_b0",     32'(b0_rs1_busy), 32'h1);
    checkOutput("wb3_fwd_b1",      b1_rs1_data, 32'h66);
    checkOutput("wb3_old_b0",      b0_rs1_data, 32'h55);
    checkOutput("iss10_pre_busy",  32'(b1_rs2_busy), 32'h0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 3, 10);
    checkOutput("wb3_data",        b1_rs1_data, 32'h66);
    checkOutput("wb3_cleared",     32'(b1_rs1_busy), 32'h0);
    checkOutput("iss10_busy",      32'(b1_rs2_busy), 32'h1);
    checkOutput("split_count_b1",  32'(b1_busy_count), 32'h1);
    checkOutput("split_count_b0",  32'(b0_busy_count), 32'h1);

    // re-issue busy x10 while its write-back lands: busy held, no conflict
    applyStimulus(1, 10, 32'h1010, 1, 10, 10, 0);
    checkOutput("reiss10_busy_b1", 32'(b1_rs1_busy), 32'h1);
    checkOutput("reiss10_fwd_b1",  b1_rs1_data, 32'h1010);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 10, 0);
    checkOutput("reiss10_count",   32'(b1_busy_count), 32'h1);
    checkOutput("reiss10_confl_b1",32'(b1_wr_conflict), 32'h0);
    checkOutput("reiss10_confl_b0",32'(b0_wr_conflict), 32'h0);
    checkOutput("reiss10_data_b0", b0_rs1_data, 32'h1010);

    // double issue to x9 raises the sticky conflict
    applyStimulus(0, 0, 0, 1, 9, 9, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 9, 0);
    checkOutput("iss9_first_confl",32'(b1_wr_conflict), 32'h0);
    checkOutput("iss9_first_count",32'(b1_busy_count), 32'h2);
    applyStimulus(0, 0, 0, 1, 9, 9, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 9, 0);
    checkOutput("iss9_confl_b1",   32'(b1_wr_conflict), 32'h1);
    checkOutput("iss9_confl_b0",   32'(b0_wr_conflict), 32'h1);
    checkOutput("iss9_count",      32'(b1_busy_count), 32'h2);
    applyStimulus(1, 9, 32'h99, 1, 2, 9, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 9, 2);
    checkOutput("sticky_confl",    32'(b1_wr_conflict), 32'h1);
    checkOutput("wb9_count",       32'(b1_busy_count), 32'h2);
    checkOutput("wb9_data",        b1_rs1_data, 32'h99);
    checkOutput("wb9_busy",        32'(b1_rs1_busy), 32'h0);
    checkOutput("iss2_busy",       32'(b1_rs2_busy), 32'h1);

    // write-back to a non-busy register
    applyStimulus(1, 12, 32'hCC, 0, 0, 12, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 12, 0);
    checkOutput("wb12_data",       b1_rs1_data, 32'hCC);
    checkOutput("wb12_busy",       32'(b1_rs1_busy), 32'h0);
    checkOutput("wb12_count",      32'(b1_busy_count), 32'h2);

    // leave x2, x4, x6 busy
    applyStimulus(1, 10, 32'h10, 1, 4, 0, 0);
    tick;
    applyStimulus(0, 0, 0, 1, 6, 0, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 2, 6);
    checkOutput("three_count_b1",  32'(b1_busy_count), 32'h3);
    checkOutput("three_count_b0",  32'(b0_busy_count), 32'h3);
    checkOutput("three_stall",     32'(b1_stall), 32'h1);

    // asynchronous reset between edges
    applyStimulus(0, 0, 0, 0, 0, 5, 12);
    checkOutput("pre_rst_rs1",     b1_rs1_data, 32'hDEADBEEF);
    checkOutput("pre_rst_rs2",     b1_rs2_data, 32'hCC);
    reset = 1'b1;
    #1;
    checkOutput("async_count_b1",  32'(b1_busy_count), 32'h0);
    checkOutput("async_count_b0",  32'(b0_busy_count), 32'h0);
    checkOutput("async_stall",     32'(b1_stall), 32'h0);
    checkOutput("async_confl_b1",  32'(b1_wr_conflict), 32'h0);
    checkOutput("async_confl_b0",  32'(b0_wr_conflict), 32'h0);
    checkOutput("async_rs1_b1",    b1_rs1_data, 32'h0);
    checkOutput("async_rs2_b1",    b1_rs2_data, 32'h0);
    checkOutput("async_rs1_b0",    b0_rs1_data, 32'h0);
    tick;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 2, 6);
    checkOutput("post_rst_stall_b1", 32'(b1_stall), 32'h0);
    checkOutput("post_rst_stall_b0", 32'(b0_stall), 32'h0);

    // first edge after release behaves normally
    applyStimulus(0, 0, 0, 1, 2, 2, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 2, 0);
    checkOutput("post_rst_iss_stall", 32'(b1_stall), 32'h1);
    checkOutput("post_rst_iss_count", 32'(b1_busy_count), 32'h1);
    checkOutput("post_rst_iss_confl", 32'(b1_wr_conflict), 32'h0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
